stream_demux_1_4: RTL and testbench

- Registered 1-to-4 stream demultiplexer with valid/ready handshake. It is the inverse of the 4:1 selector: one input stream is steered to one of four output channels by a 2-bit select.
- Each output channel has a one-entry holding register, so a stalled consumer blocks only the transfers addressed to it.
- Sits between a single producer and four independent consumers in the datapath.

---
 rtl/stream_demux_1_4_if.sv | 26 ++
 rtl/stream_demux_1_4.sv | 81 ++++++++
 tb/tb_stream_demux_1_4.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_1_4_if.sv
// Handshake bundle for the 1:4 stream demultiplexer: one input stream, four output channels.
// master = producer/consumers side, slave = demux side.
interface stream_demux_1_4_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data0;
  logic [W-1:0] out_data1;
  logic [W-1:0] out_data2;
  logic [W-1:0] out_data3;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );
endinterface

// File: rtl/stream_demux_1_4.sv
// Registered 1:4 stream demux, one holding register per channel; DEMUX_RR_SEL_EN selects round-robin steering.
// Latency one cycle; in_ready reflects only the addressed channel, so one stalled consumer blocks only its own traffic.
module stream_demux_1_4 #(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_demux_1_4_if.slave   bus
);

  logic [1:0]   dst;
  logic         accept;
  logic [3:0]   acc_hit;
  logic [3:0]   valid_q;
  logic [3:0]   valid_d;
  logic [W-1:0] data_q [4];

`ifdef DEMUX_RR_SEL_EN
  logic [1:0] rr_ptr;
  logic       unused_sel;

  // Pointer advances only on an accepted word, so a stall holds the rotation in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
    end else if (accept) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end

  assign dst        = rr_ptr;
  assign unused_sel = ^bus.in_sel;
`else
  assign dst = bus.in_sel;
`endif

  assign bus.in_ready = ~valid_q[dst] | bus.out_ready[dst];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    acc_hit = 4'b0000;
    if (accept) begin
      acc_hit[dst] = 1'b1;
    end
  end

  // Drain clears a channel unless a new word lands in it on the same edge.
  always_comb begin
    valid_d = valid_q & ~bus.out_ready;
    valid_d = valid_d | acc_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc_hit[i]) begin
          data_q[i] <= bus.in_data;
        end
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data0 = data_q[0];
  assign bus.out_data1 = data_q[1];
  assign bus.out_data2 = data_q[2];
  assign bus.out_data3 = data_q[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: directed scenarios plus random traffic against a per-channel occupancy model.
module tb_stream_demux_1_4;
  localparam int W = 4;
`ifdef DEMUX_RR_SEL_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_demux_1_4_if #(.W(W)) bus ();
  stream_demux_1_4 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: each channel either holds a word or not; last word is retained after draining.
  logic [3:0]   m_vld;
  logic [W-1:0] m_dat [4];
  int           m_ptr;
  logic         last_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_vld = 4'b0000;
    for (int i = 0; i < 4; i++) m_dat[i] = '0;
    m_ptr = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_vld"},   32'(bus.out_valid), 32'(m_vld));
    check({tag, "_data0"}, 32'(bus.out_data0), 32'(m_dat[0]));
    check({tag, "_data1"}, 32'(bus.out_data1), 32'(m_dat[1]));
    check({tag, "_data2"}, 32'(bus.out_data2), 32'(m_dat[2]));
    check({tag, "_data3"}, 32'(bus.out_data3), 32'(m_dat[3]));
  endtask

  // Called at a falling edge: drive inputs, check ready, clock once, check outputs.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r);
    int   dst;
    logic exp_rdy;
    logic acc;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    dst     = RR ? m_ptr : int'(s);
    exp_rdy = !m_vld[dst] || r[dst];
    last_rdy = bus.in_ready;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (m_vld[i] && r[i]) m_vld[i] = 1'b0;
    end
    if (acc) begin
      m_vld[dst] = 1'b1;
      m_dat[dst] = d;
      m_ptr      = (m_ptr + 1) % 4;
    end
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 4'b0000;
    #1;
    model_clear();
    check_outputs("rst");
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 4'b0000;
    model_clear();
    @(negedge clk);
    do_reset();

`ifndef DEMUX_RR_SEL_EN
    // Single word to channel 2
    cycle(1'b1, 2'd2, 4'hA, 4'b0000);
    check("t1_vld",   32'(bus.out_valid), 32'(4'b0100));
    check("t1_data2", 32'(bus.out_data2), 32'(4'hA));
    check("t1_data0", 32'(bus.out_data0), 32'(0));

    // Stalled channel 1, then replacement on the releasing edge
    do_reset();
    cycle(1'b1, 2'd1, 4'h3, 4'b0000);
    cycle(1'b1, 2'd1, 4'h7, 4'b0000);
    check("t2_stall_rdy", 32'(last_rdy), 32'(0));
    check("t2_hold",      32'(bus.out_data1), 32'(4'h3));
    cycle(1'b1, 2'd1, 4'h7, 4'b0010);
    check("t2_rel_rdy",   32'(last_rdy), 32'(1));
    check("t2_new",       32'(bus.out_data1), 32'(4'h7));
    check("t2_vld",       32'(bus.out_valid), 32'(4'b0010));

    // Channel 0 stalled does not block channel 3
    do_reset();
    cycle(1'b1, 2'd0, 4'h5, 4'b0000);
    cycle(1'b1, 2'd3, 4'hC, 4'b0000);
    check("t4_rdy",   32'(last_rdy), 32'(1));
    check("t4_data3", 32'(bus.out_data3), 32'(4'hC));
    check("t4_data0", 32'(bus.out_data0), 32'(4'h5));
    check("t4_vld",   32'(bus.out_valid), 32'(4'b1001));
`endif

    // Back-to-back words to channels 0..3, all consumers ready
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 2'(k), 4'(k + 1), 4'b1111);
      check("t3_vld", 32'(bus.out_valid), 32'(1 << k));
      check("t3_rdy", 32'(last_rdy), 32'(1));
    end
    cycle(1'b0, 2'd0, 4'h0, 4'b1111);
    check("t3_idle", 32'(bus.out_valid), 32'(0));
    check("t3_hold3", 32'(bus.out_data3), 32'(4'h4));

    // Asynchronous reset with channels 0, 1 and 3 occupied
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 2'(k), 4'(k + 8), 4'b0000);
    cycle(1'b0, 2'd0, 4'h0, 4'b0100);
    check("t5_pre", 32'(bus.out_valid), 32'(4'b1011));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_vld", 32'(bus.out_valid), 32'(0));
    model_clear();
    check_outputs("t5");
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    rst_n = 1'b1;

`ifdef DEMUX_RR_SEL_EN
    // Fixed in_sel=3 is ignored; words rotate 0,1,2,3,0,1
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 2'd3, 4'(k), 4'b1111);
      check("t6_vld", 32'(bus.out_valid), 32'(1 << (k % 4)));
    end
    check("t6_data0", 32'(bus.out_data0), 32'(4'h4));
    check("t6_data1", 32'(bus.out_data1), 32'(4'h5));
    // Channel 2 stalled: pointer waits at 2
    do_reset();
    for (int k = 0; k < 6; k++) cycle(1'b1, 2'd3, 4'(k), 4'b1011);
    cycle(1'b1, 2'd3, 4'h6, 4'b1011);
    check("t6_stall_rdy", 32'(last_rdy), 32'(0));
    check("t6_stall_d2",  32'(bus.out_data2), 32'(4'h2));
    cycle(1'b1, 2'd3, 4'h6, 4'b1111);
    check("t6_rel_rdy", 32'(last_rdy), 32'(1));
    check("t6_rel_d2",  32'(bus.out_data2), 32'(4'h6));
    cycle(1'b1, 2'd0, 4'h9, 4'b1111);
    check("t6_next_d3", 32'(bus.out_data3), 32'(4'h9));
`endif

    // Random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
